mux_2_1_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2:1 mux datapath between two requesters, A and B.
- It grants one requester at a time and drives the mux select.
- It registers the selected beat into a single output stage with a valid/ready handshake.
- Grants are held per packet, delimited by last, and capped at MAX_BEATS beats per grant for fairness.

---
 rtl/mux_2_1_arbiter.sv | 121 ++++++++++++
 tb/tb_mux_2_1_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2_1_arbiter.sv
// Round-robin arbiter sharing a 2:1 mux between requesters A and B. Grants are
// held per packet (capped at MAX_BEATS beats) and feed one valid/ready output register.
module mux_2_1_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(MAX_BEATS - 1);

  state_t           r_state;
  logic             r_prio;
  logic             r_sel;
  logic [7:0]       r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;

  logic             w_space;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic             w_acc_a;
  logic             w_acc_b;
  logic             w_acc;
  logic [WIDTH-1:0] w_acc_data;
  logic             w_acc_last;
  logic             w_release;

  // The output stage can take a beat when empty or when its beat leaves this cycle.
  assign w_space    = !r_out_valid || out_ready;
  assign w_gnt_a    = (r_state == ST_GNT_A) && w_space;
  assign w_gnt_b    = (r_state == ST_GNT_B) && w_space;
  assign w_acc_a    = w_gnt_a && req_a;
  assign w_acc_b    = w_gnt_b && req_b;
  assign w_acc      = w_acc_a || w_acc_b;
  assign w_acc_data = w_acc_b ? data_b : data_a;
  assign w_acc_last = w_acc_b ? last_b : last_a;
  assign w_release  = w_acc && (w_acc_last || (r_cnt == LP_CNT_LAST));

  // Grant FSM, beat counter, round-robin priority and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prio      <= 1'b0;
      r_sel       <= 1'b0;
      r_cnt       <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_data;
        r_out_last  <= w_acc_last;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end

      case (r_state)
        ST_IDLE: begin
          if (req_a && (!req_b || !r_prio)) begin
            r_state <= ST_GNT_A;
            r_sel   <= 1'b0;
          end else if (req_b) begin
            r_state <= ST_GNT_B;
            r_sel   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GNT_A, ST_GNT_B: begin
          // A capped release does not touch out_last; the packet resumes later.
          if (w_release) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_prio  <= (r_state == ST_GNT_A);
          end else if (w_acc) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign gnt_a     = w_gnt_a;
  assign gnt_b     = w_gnt_b;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Directed bench for mux_2_1_arbiter: a transaction-level model of ownership,
// fairness and the output slot is compared against the DUT every cycle.
module tb_mux_2_1_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;

  typedef logic [WIDTH:0] beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_a = 1'b0, last_a = 1'b0, req_b = 1'b0, last_b = 1'b0;
  logic [WIDTH-1:0] data_a = '0, data_b = '0;
  logic             out_ready = 1'b1;
  logic             gnt_a, gnt_b, sel, out_valid, out_last;
  logic [WIDTH-1:0] out_data;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Model: who owns the datapath, whose turn is next, beats taken in this grant.
  int         m_owner;
  logic       m_turn_b;
  logic       m_sel;
  int         m_taken;
  logic       m_ov;
  logic [WIDTH-1:0] m_od;
  logic       m_ol;
  logic       m_acc_a, m_acc_b;
  beat_t      m_log[$];
  beat_t      m_out[$];

  beat_t qa[$];
  beat_t qb[$];
  logic  hold_a = 1'b0;

  mux_2_1_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .last_a(last_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .last_b(last_b), .gnt_b(gnt_b),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string name, input beat_t got[$], input beat_t exp[$]);
    check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(name, 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic model_reset();
    m_owner = 0; m_turn_b = 1'b0; m_sel = 1'b0; m_taken = 0;
    m_ov = 1'b0; m_od = '0; m_ol = 1'b0;
    m_acc_a = 1'b0; m_acc_b = 1'b0;
  endtask

  // Advance the model by one clock using the inputs the DUT sampled.
  task automatic model_step();
    logic  space, acc;
    beat_t b;
    m_acc_a = 1'b0;
    m_acc_b = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      space = !m_ov || out_ready;
      if (m_ov && out_ready) m_out.push_back({m_od, m_ol});
      if (m_owner == 0) begin
        if (req_a && (!req_b || !m_turn_b)) begin
          m_owner = 1; m_sel = 1'b0;
        end else if (req_b) begin
          m_owner = 2; m_sel = 1'b1;
        end
        if (m_ov && out_ready) m_ov = 1'b0;
      end else begin
        acc = space && ((m_owner == 1) ? req_a : req_b);
        if (acc) begin
          b = (m_owner == 1) ? {data_a, last_a} : {data_b, last_b};
          m_acc_a = (m_owner == 1);
          m_acc_b = (m_owner == 2);
          m_log.push_back(b);
          m_od = b[WIDTH:1];
          m_ol = b[0];
          m_ov = 1'b1;
          m_taken++;
          if (b[0] || m_taken == MAX_BEATS) begin
            m_turn_b = (m_owner == 1);
            m_owner  = 0;
            m_taken  = 0;
          end
        end else if (m_ov && out_ready) begin
          m_ov = 1'b0;
        end
      end
    end
  endtask

  task automatic apply();
    req_a  = (qa.size() > 0) && !hold_a;
    data_a = (qa.size() > 0) ? qa[0][WIDTH:1] : '0;
    last_a = (qa.size() > 0) ? qa[0][0] : 1'b0;
    req_b  = (qb.size() > 0);
    data_b = (qb.size() > 0) ? qb[0][WIDTH:1] : '0;
    last_b = (qb.size() > 0) ? qb[0][0] : 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      apply();
      @(posedge clk);
      model_step();
      #2;
      if (m_acc_a && qa.size() > 0) void'(qa.pop_front());
      if (m_acc_b && qb.size() > 0) void'(qb.pop_front());
    end
    apply();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || m_ov || m_owner != 0) && n < 60) begin
      run(1);
      n++;
    end
    check(name, 32'(n >= 60), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    qa.delete(); qb.delete();
    run(2);
    rst_n = 1'b1;
    m_log.delete(); m_out.delete();
  endtask

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt_a", 32'(gnt_a), 32'(rst_n && m_owner == 1 && (!m_ov || out_ready)));
      check("gnt_b", 32'(gnt_b), 32'(rst_n && m_owner == 2 && (!m_ov || out_ready)));
      check("sel", 32'(sel), 32'(m_sel));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_last", 32'(out_last), 32'(m_ol));
      end
    end
  end

  initial begin
    beat_t e[$];
    model_reset();
    run(1);
    chk_en = 1'b1;
    do_reset();

    // Reset state.
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_sel", 32'(sel), 32'd0);

    // Single-beat A packet: grant one cycle after request, output one cycle later.
    qa.push_back({8'hA1, 1'b1});
    run(1);
    check("t1_gnt_a", 32'(gnt_a), 32'd1);
    run(1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'hA1);
    check("t1_last", 32'(out_last), 32'd1);
    check("t1_prio_b", 32'(m_turn_b), 32'd1);
    drain("t1_drain");

    // Both requesting single beats: strict alternation starting with A.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      qa.push_back({8'h11, 1'b1});
      qb.push_back({8'h22, 1'b1});
    end
    run(8);
    qa.delete(); qb.delete();
    drain("t2_drain");
    e = '{{8'h11, 1'b1}, {8'h22, 1'b1}, {8'h11, 1'b1}, {8'h22, 1'b1}};
    check_seq("t2_seq", m_log, e);

    // Six-beat A packet capped at four beats, B interleaved, A resumes.
    m_log.delete();
    for (int i = 0; i < 6; i++) qa.push_back({8'(i), 1'(i == 5)});
    qb.push_back({8'hB0, 1'b1});
    drain("t3_drain");
    e = '{{8'h00, 1'b0}, {8'h01, 1'b0}, {8'h02, 1'b0}, {8'h03, 1'b0},
          {8'hB0, 1'b1}, {8'h04, 1'b0}, {8'h05, 1'b1}};
    check_seq("t3_seq", m_log, e);

    // Backpressure during a B grant: output holds, nothing lost or duplicated.
    m_log.delete(); m_out.delete();
    qb = '{{8'hC0, 1'b0}, {8'hC1, 1'b0}, {8'hC2, 1'b1}};
    run(2);
    out_ready = 1'b0;
    #1;
    check("t4_stall_gnt_b", 32'(gnt_b), 32'd0);
    run(3);
    check("t4_hold_data", 32'(out_data), 32'hC0);
    check("t4_hold_last", 32'(out_last), 32'd0);
    out_ready = 1'b1;
    drain("t4_drain");
    e = '{{8'hC0, 1'b0}, {8'hC1, 1'b0}, {8'hC2, 1'b1}};
    check_seq("t4_out", m_out, e);

    // A pauses mid-packet; B keeps requesting but must wait for A's last.
    do_reset();
    qa = '{{8'hD0, 1'b0}, {8'hD1, 1'b0}, {8'hD2, 1'b1}};
    qb = '{{8'hE0, 1'b1}};
    run(2);
    hold_a = 1'b1;
    run(2);
    check("t5_gnt_b_idle", 32'(gnt_b), 32'd0);
    check("t5_sel", 32'(sel), 32'd0);
    hold_a = 1'b0;
    drain("t5_drain");
    e = '{{8'hD0, 1'b0}, {8'hD1, 1'b0}, {8'hD2, 1'b1}, {8'hE0, 1'b1}};
    check_seq("t5_seq", m_log, e);

    // Reset in the middle of an A packet, then B alone is served.
    do_reset();
    qa = '{{8'hF0, 1'b0}, {8'hF1, 1'b0}, {8'hF2, 1'b1}};
    run(3);
    rst_n = 1'b0;
    model_reset();
    qa.delete();
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_gnt_a", 32'(gnt_a), 32'd0);
    check("t6_rst_sel", 32'(sel), 32'd0);
    run(2);
    rst_n = 1'b1;
    m_log.delete();
    qb = '{{8'h5A, 1'b1}};
    run(1);
    check("t6_sel_b", 32'(sel), 32'd1);
    drain("t6_drain");
    e = '{{8'h5A, 1'b1}};
    check_seq("t6_seq", m_log, e);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
